uart_tx_buffered: RTL and testbench

//  Parametrised UART transmitter with a transmit FIFO, configurable frame format and runtime baud divisor.

---
 rtl/uart_tx_buffered_pkg.sv | 43 ++++
 rtl/uart_tx_buffered_if.sv | 30 +++
 rtl/uart_tx_buffered_sync_fifo.sv | 91 +++++++++
 rtl/uart_tx_buffered.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_pkg
//  Shared definitions for the buffered UART transmitter:
//   - parity mode constants (none / odd / even)
//   - the default baud divisor for a 100 MHz clock at 9600 baud
//   - the transmit FSM state encoding
//   - a parity helper used by the frame generator
//  No ports; imported by the top and by anything that needs the encodings.
// -----------------------------------------------------------------------------
package uart_tx_buffered_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // One bit period is divisor+1 clocks: 100e6 / 9600 = 10416.7 -> 10417 clocks.
    localparam int CD_DEFAULT_100M_9600 = 10416;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity over the low nbits of word. Even parity returns the XOR of the
    // data bits, odd parity its complement, so the total count of ones in
    // data+parity is even / odd respectively.
    function automatic logic parity_bit(input logic [8:0] word,
                                        input int         nbits,
                                        input int         mode);
        logic p;
        p = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < nbits) begin
                p = p ^ word[k];
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
//  Write-side handshake between a producer and the buffered UART transmitter.
//   tbus    producer -> tx   word to transmit (DATA_BITS wide)
//   tstart  producer -> tx   write strobe, word taken on a clock edge where
//                            tstart && ready
//   ready   tx -> producer   FIFO not full (registered)
//  Modports: master = producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tbus;
    logic                 tstart;
    logic                 ready;

    modport master (
        output tbus,
        output tstart,
        input  ready
    );

    modport slave (
        input  tbus,
        input  tstart,
        output ready
    );

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//  Single-clock FIFO used as the transmit buffer.
//  Ports:
//   clk, rstn   clock, asynchronous active-low reset (pointers/count only)
//   push,wdata  write request; ignored while full (even with a pop that cycle)
//   pop         read request; ignored while empty
//   rdata       registered read data, valid the cycle after an accepted pop
//   full        registered, depends on occupancy only
//   empty       read and write pointers equal
//   count       registered occupancy 0..DEPTH
//  The storage array has no reset so it maps onto block/distributed RAM.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Pointers carry one extra MSB: equal pointers mean empty, pointers that
    // differ only in the MSB mean full.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] count_q;
    logic [AW:0] count_d;
    logic        full_q;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = full_q;
    assign count   = count_q;
    assign rdata   = rdata_q;

    // A push at full is refused even if a pop frees a slot in the same cycle,
    // so acceptance only ever depends on the registered full flag.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
        if (do_pop) begin
            rdata_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//  UART transmitter with a transmit FIFO, configurable frame format
//  (DATA_BITS 5..9 LSB first, PARITY none/odd/even, STOP_BITS 1 or 2) and a
//  runtime baud divisor (bit period = divisor+1 clocks).
//  Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset, synchronous release
//   wr          write handshake (tbus / tstart / ready), slave side
//   cd_max      bit-period divisor, sampled only when a frame starts
//   cd_load     1 = use cd_max, 0 = use CD_DEFAULT
//   tx          serial line, idle high, driven straight from a flop
//   busy        frame in progress or FIFO not empty
//   fifo_count  FIFO occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int CD_WIDTH   = 16,
    parameter int CD_DEFAULT = CD_DEFAULT_100M_9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    uart_tx_buffered_if.slave             wr,
    input  logic [CD_WIDTH-1:0]           cd_max,
    input  logic                          cd_load,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int IW = 4;
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    // FIFO side
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;

    // Frame generator state
    tx_state_e            state_q;
    logic                 tx_q;
    logic [CD_WIDTH-1:0]  cnt_q;
    logic [CD_WIDTH-1:0]  div_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 load_q;   // IDLE: word popped, read data lands next cycle
    logic                 latch_q;  // START: word popped at STOP end, take it from FIFO

    logic [CD_WIDTH-1:0]  div_sel;
    logic                 bit_end;
    logic                 stop_last;
    logic [DATA_BITS-1:0] cur_word;
    logic [IW-1:0]        nxt_idx;
    logic [DATA_BITS-1:0] word_shr;

    assign fifo_push = wr.tstart && !fifo_full;
    assign wr.ready  = !fifo_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata (wr.tbus),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign div_sel   = cd_load ? cd_max : CD_WIDTH'(CD_DEFAULT);
    assign bit_end   = (cnt_q == div_q);
    assign stop_last = (state_q == ST_STOP) && bit_end && (bit_idx_q == LAST_STOP);

    // In the first START cycle after a back-to-back pop the word is still in
    // the FIFO read register; with a one-clock bit period it is needed there.
    assign cur_word  = latch_q ? fifo_rdata : word_q;
    assign nxt_idx   = bit_idx_q + IW'(1);
    assign word_shr  = word_q >> nxt_idx;

    // Pop once from IDLE (then wait one cycle for read data), or at the last
    // clock of the final stop bit so the next start bit follows with no gap.
    assign fifo_pop  = ((state_q == ST_IDLE) && !load_q && !fifo_empty) ||
                       (stop_last && !fifo_empty);

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE) || load_q || (fifo_count != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_idx_q <= '0;
            word_q    <= '0;
            load_q    <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_q) begin
                        load_q  <= 1'b0;
                        word_q  <= fifo_rdata;
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end else begin
                        tx_q <= 1'b1;
                        if (!fifo_empty) begin
                            load_q <= 1'b1;
                            div_q  <= div_sel;
                        end
                    end
                end

                ST_START: begin
                    if (latch_q) begin
                        word_q  <= fifo_rdata;
                        latch_q <= 1'b0;
                    end
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= cur_word[0];
                        state_q   <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CD_WIDTH'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == LAST_DATA) begin
                            bit_idx_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_q    <= parity_bit(9'(word_q), DATA_BITS, PARITY);
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= nxt_idx;
                            tx_q      <= word_shr[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + CD_WIDTH'(1);
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CD_WIDTH'(1);
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == LAST_STOP) begin
                            bit_idx_q <= '0;
                            if (!fifo_empty) begin
                                // Back-to-back frame: divisor re-sampled here.
                                div_q   <= div_sel;
                                latch_q <= 1'b1;
                                tx_q    <= 1'b0;
                                state_q <= ST_START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bit_idx_q <= nxt_idx;
                        end
                    end else begin
                        cnt_q <= cnt_q + CD_WIDTH'(1);
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

    logic        clk = 1'b0;
    logic        rstn;
    logic [8:0]  tbus_tb;
    logic        tstart_tb;
    logic [15:0] cd_max_tb;
    logic        cd_load_tb;
    int          sel;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       tx0, tx1, tx2, tx3;
    logic       busy0, busy1, busy2, busy3;
    logic [4:0] cnt0, cnt1, cnt2, cnt3;

    uart_tx_buffered_if #(.DATA_BITS(8)) if0 ();
    uart_tx_buffered_if #(.DATA_BITS(8)) if1 ();
    uart_tx_buffered_if #(.DATA_BITS(8)) if2 ();
    uart_tx_buffered_if #(.DATA_BITS(5)) if3 ();

    assign if0.tbus = tbus_tb[7:0];
    assign if1.tbus = tbus_tb[7:0];
    assign if2.tbus = tbus_tb[7:0];
    assign if3.tbus = tbus_tb[4:0];
    assign if0.tstart = tstart_tb && (sel == 0);
    assign if1.tstart = tstart_tb && (sel == 1);
    assign if2.tstart = tstart_tb && (sel == 2);
    assign if3.tstart = tstart_tb && (sel == 3);

    // u0: 8N1 with a scaled-down default divisor (10 clocks per bit)
    uart_tx_buffered #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CD_WIDTH(16),
                       .CD_DEFAULT(9), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rstn(rstn), .wr(if0), .cd_max(cd_max_tb), .cd_load(cd_load_tb),
        .tx(tx0), .busy(busy0), .fifo_count(cnt0));
    // u1: 8O1
    uart_tx_buffered #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CD_WIDTH(16),
                       .CD_DEFAULT(9), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rstn(rstn), .wr(if1), .cd_max(cd_max_tb), .cd_load(cd_load_tb),
        .tx(tx1), .busy(busy1), .fifo_count(cnt1));
    // u2: 8E2
    uart_tx_buffered #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CD_WIDTH(16),
                       .CD_DEFAULT(9), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rstn(rstn), .wr(if2), .cd_max(cd_max_tb), .cd_load(cd_load_tb),
        .tx(tx2), .busy(busy2), .fifo_count(cnt2));
    // u3: 5N1
    uart_tx_buffered #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .CD_WIDTH(16),
                       .CD_DEFAULT(9), .FIFO_DEPTH(16)) u3 (
        .clk(clk), .rstn(rstn), .wr(if3), .cd_max(cd_max_tb), .cd_load(cd_load_tb),
        .tx(tx3), .busy(busy3), .fifo_count(cnt3));

    int cfg_db  [4] = '{8, 8, 8, 5};
    int cfg_par [4] = '{0, 1, 2, 0};
    int cfg_sb  [4] = '{1, 1, 2, 1};

    typedef struct packed {
        logic [8:0] data;
        int         per;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_start = 0;
    int   last_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, dut u%0d)", tag, got, exp, cyc, sel);
        end
    endtask

    function automatic logic cur_tx();
        case (sel)
            0: return tx0;
            1: return tx1;
            2: return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic cur_busy();
        case (sel)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    function automatic logic cur_ready();
        case (sel)
            0: return if0.ready;
            1: return if1.ready;
            2: return if2.ready;
            default: return if3.ready;
        endcase
    endfunction

    function automatic logic [31:0] cur_count();
        case (sel)
            0: return 32'(cnt0);
            1: return 32'(cnt1);
            2: return 32'(cnt2);
            default: return 32'(cnt3);
        endcase
    endfunction

    function automatic int frame_bits(input int s);
        return 1 + cfg_db[s] + ((cfg_par[s] != 0) ? 1 : 0) + cfg_sb[s];
    endfunction

    // Expected line level for bit k of a frame: start, data LSB first, parity, stops.
    function automatic logic exp_bit(input int s, input logic [8:0] d, input int k);
        logic ones;
        if (k == 0) return 1'b0;
        if (k <= cfg_db[s]) return d[k-1];
        if (cfg_par[s] != 0 && k == cfg_db[s] + 1) begin
            ones = 1'b0;
            for (int j = 0; j < cfg_db[s]; j++) ones = ones ^ d[j];
            return (cfg_par[s] == 2) ? ones : ~ones;
        end
        return 1'b1;
    endfunction

    // Called at a negedge; the accepting edge is the next posedge.
    task automatic wr_word(input logic [8:0] d, input int per, input bit exp_acc);
        exp_t e;
        tbus_tb   = d;
        tstart_tb = 1'b1;
        check("ready", cur_ready(), exp_acc);
        if (exp_acc) begin
            e.data = d;
            e.per  = per;
            sb_q.push_back(e);
        end
        $display("[%0d] wr u%0d data=0x%0h accept=%0d", cyc, sel, d, exp_acc);
        @(negedge clk);
        tstart_tb = 1'b0;
    endtask

    task automatic wait_start(output int t, input int bound);
        int w = 0;
        while (cur_tx() !== 1'b0 && w < bound) begin
            @(negedge clk);
            w++;
        end
        check("start_seen", (w < bound), 1);
        t = cyc;
    endtask

    task automatic recv(input bit chk_gap, input bit chk_end);
        exp_t e;
        int   n, t0, pos, tgt;
        wait_start(t0, 3000);
        if (sb_q.size() == 0) begin
            check("sb_has_entry", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        n = frame_bits(sel);
        if (chk_gap) check("frame_gap", t0 - last_start, last_len);
        last_start = t0;
        last_len   = n * e.per;
        pos = 0;
        for (int k = 0; k < n; k++) begin
            tgt = k * e.per + (e.per - 1) / 2;
            while (pos < tgt) begin
                @(negedge clk);
                pos++;
            end
            check($sformatf("bit%0d", k), cur_tx(), exp_bit(sel, e.data, k));
        end
        if (chk_end) begin
            tgt = n * e.per - 1;
            while (pos < tgt) begin
                @(negedge clk);
                pos++;
            end
            check("busy_last_clk", cur_busy(), 1);
            @(negedge clk);
            check("busy_after", cur_busy(), 0);
        end
        $display("[%0d] rx u%0d data=0x%0h per=%0d", cyc, sel, e.data, e.per);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int quiet;
        rstn       = 1'b0;
        tbus_tb    = '0;
        tstart_tb  = 1'b0;
        cd_max_tb  = '0;
        cd_load_tb = 1'b0;
        sel        = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            check("rst_tx", cur_tx(), 1);
            check("rst_ready", cur_ready(), 1);
            check("rst_busy", cur_busy(), 0);
            check("rst_count", cur_count(), 0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 with default divisor: latency and full frame
        sel = 0;
        cd_load_tb = 1'b0;
        wr_word(9'h055, 10, 1);
        check("lat_edge0", cur_tx(), 1);
        @(negedge clk);
        check("lat_edge1", cur_tx(), 1);
        @(negedge clk);
        check("lat_edge2", cur_tx(), 0);
        recv(0, 1);

        // 8O1 and 8E2 with divisor 3
        cd_load_tb = 1'b1;
        cd_max_tb  = 16'd3;
        sel = 1;
        @(negedge clk);
        wr_word(9'h007, 4, 1);
        recv(0, 1);
        sel = 2;
        @(negedge clk);
        wr_word(9'h007, 4, 1);
        recv(0, 1);

        // Burst of 20 behind a running frame, then push at full with a pop
        sel = 0;
        @(negedge clk);
        fork
            begin
                wr_word(9'h0A0, 4, 1);
                wait_start(t, 50);
                for (int i = 0; i < 20; i++) wr_word(9'((i * 7 + 1) & 8'hFF), 4, (i < 16));
                check("burst_count", cur_count(), 16);
                check("burst_ready", cur_ready(), 0);
                while (cyc < t + 39) @(negedge clk);
                check("full_pre_pop", cur_count(), 16);
                wr_word(9'h03C, 4, 0);
                check("full_push_pop", cur_count(), 15);
            end
            begin
                recv(0, 0);
                for (int i = 1; i <= 16; i++) recv(1, (i == 16));
            end
        join

        // Push and pop in the same cycle at count 5
        @(negedge clk);
        fork
            begin
                wr_word(9'h011, 4, 1);
                wait_start(t, 50);
                for (int i = 0; i < 5; i++) wr_word(9'(8'h20 + i), 4, 1);
                while (cyc < t + 39) @(negedge clk);
                check("cnt5_pre", cur_count(), 5);
                wr_word(9'h02F, 4, 1);
                check("cnt5_post", cur_count(), 5);
            end
            begin
                recv(0, 0);
                for (int i = 0; i < 6; i++) recv(1, (i == 5));
            end
        join

        // Reset in the middle of DATA with three words queued
        cd_load_tb = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) wr_word(9'(8'hC0 + i), 10, 1);
        wait_start(t, 50);
        while (cyc < t + 35) @(negedge clk);
        check("pre_rst_count", cur_count(), 3);
        rstn = 1'b0;
        #1;
        check("mid_rst_tx", cur_tx(), 1);
        check("mid_rst_count", cur_count(), 0);
        check("mid_rst_busy", cur_busy(), 0);
        check("mid_rst_ready", cur_ready(), 1);
        sb_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        quiet = 0;
        repeat (300) begin
            @(negedge clk);
            if (cur_tx() !== 1'b1 || cur_busy() !== 1'b0) quiet++;
        end
        check("post_rst_quiet", quiet, 0);

        // 5-bit frames, divisor changed during the first frame
        sel = 3;
        cd_load_tb = 1'b1;
        cd_max_tb  = 16'd3;
        @(negedge clk);
        fork
            begin
                wr_word(9'h01F, 4, 1);
                wr_word(9'h00B, 2, 1);
                wait_start(t, 50);
                repeat (6) @(negedge clk);
                cd_max_tb = 16'd1;
            end
            begin
                recv(0, 0);
                recv(1, 1);
            end
        join

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
